// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Pipeline boundary register with valid/ready handshake,
//                one-entry skid buffer, synchronous flush (bubble insert)
//                and registered-destination forwarding match flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned CTRL_W   = 9,
  parameter int unsigned WREG_BIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic [REG_W-1:0]  ra_i,
  input  logic [REG_W-1:0]  rb_i,
  input  logic [REG_W-1:0]  dest_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] opa_o,
  output logic [DATA_W-1:0] opb_o,
  output logic [REG_W-1:0]  ra_o,
  output logic [REG_W-1:0]  rb_o,
  output logic [REG_W-1:0]  dest_o,
  output logic [1:0]        occ,
  output logic              fwd_a,
  output logic              fwd_b
);

  // Non-control payload packed as {opa, opb, ra, rb, dest}
  localparam int unsigned DW = 2 * DATA_W + 3 * REG_W;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q,   in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DW-1:0]     main_data_q,  main_data_d;
  logic [DW-1:0]     skid_data_q,  skid_data_d;

  logic          accept;
  logic          drain;
  logic [DW-1:0] in_data;

  assign in_data = {opa_i, opb_i, ra_i, rb_i, dest_i};
  assign accept  = in_valid & in_ready_q & ~flush;
  assign drain   = main_valid_q & out_ready;

  // Next-state: flush dominates, then fill main, refill on drain, or park in skid
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Data fields hold; only validity and control are killed
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
    end else if (!main_valid_q) begin
      // Main empty implies skid empty, so a new entry goes straight to main
      if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = ctrl_i;
        main_data_d  = in_data;
      end
    end else if (drain) begin
      if (skid_valid_q) begin
        // Skid is older than anything upstream; in_ready was low so no accept
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else if (accept) begin
        main_ctrl_d  = ctrl_i;
        main_data_d  = in_data;
      end else begin
        // Bubble: no side-effecting control leaves an empty stage
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = ctrl_i;
      skid_data_d  = in_data;
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers; reset clears everything and opens the input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign ctrl_o    = main_ctrl_q;
  assign {opa_o, opb_o, ra_o, rb_o, dest_o} = main_data_q;
  assign occ       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Forwarding match against the held entry; register 0 is not special
  assign fwd_a = main_valid_q & main_ctrl_q[WREG_BIT] & (dest_o == ra_i);
  assign fwd_b = main_valid_q & main_ctrl_q[WREG_BIT] & (dest_o == rb_i);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg against a depth-2
//                FIFO reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 4;
  localparam int CTRL_W   = 9;
  localparam int WREG_BIT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] opa_i, opb_i;
  logic [REG_W-1:0]  ra_i, rb_i, dest_i;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] opa_o, opb_o;
  logic [REG_W-1:0]  ra_o, rb_o, dest_o;
  logic [1:0]        occ;
  logic              fwd_a, fwd_b;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .WREG_BIT(WREG_BIT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_i(ctrl_i), .opa_i(opa_i), .opb_i(opb_i),
    .ra_i(ra_i), .rb_i(rb_i), .dest_i(dest_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_o(ctrl_o), .opa_o(opa_o), .opb_o(opb_o),
    .ra_o(ra_o), .rb_o(rb_o), .dest_o(dest_o),
    .occ(occ), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  dest;
  } entry_t;

  // Reference: stage behaves as a FIFO of depth 2; in_ready = fewer than 2 held
  entry_t q[$];
  entry_t last;          // payload last presented on the outputs
  int n_checks = 0;
  int n_fail   = 0;

  localparam int VW = 1 + CTRL_W + 2 * DATA_W + 3 * REG_W + 2 + 1 + 2;
  logic [VW-1:0] dut_vec;
  assign dut_vec = {out_valid, ctrl_o, opa_o, opb_o, ra_o, rb_o, dest_o,
                    occ, in_ready, fwd_a, fwd_b};
  localparam logic [VW-1:0] RESET_VEC = VW'(4);   // only in_ready set

  function automatic logic [VW-1:0] model_vec();
    logic              v;
    entry_t            h;
    logic [CTRL_W-1:0] c;
    logic              fa, fb;
    v  = (q.size() > 0);
    h  = v ? q[0] : last;
    c  = v ? h.ctrl : '0;
    fa = v && h.ctrl[WREG_BIT] && (h.dest == ra_i);
    fb = v && h.ctrl[WREG_BIT] && (h.dest == rb_i);
    return {v, c, h.opa, h.opb, h.ra, h.rb, h.dest,
            2'(q.size()), (q.size() < 2), fa, fb};
  endfunction

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [REG_W-1:0] xa, input logic [REG_W-1:0] xb,
                       input logic [REG_W-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    ctrl_i    = c;
    opa_i     = a;
    opb_i     = b;
    ra_i      = xa;
    rb_i      = xb;
    dest_i    = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge
  task automatic tick();
    logic   acc, drn;
    entry_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      last = '0;
    end else begin
      acc = in_valid && (q.size() < 2) && !flush;
      drn = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          e.ctrl = ctrl_i; e.opa = opa_i; e.opb = opb_i;
          e.ra = ra_i; e.rb = rb_i; e.dest = dest_i;
          q.push_back(e);
        end
      end
      if (q.size() > 0) last = q[0];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, '0, '0, '0, '0, '0, '0, 0, 0);
    tick();
    #1;
    n_checks++;
    if (dut_vec !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, RESET_VEC);
    end
    rst = 1'b0;
    tick();
    #1;
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 8; k++) begin
      drive(1, 9'($urandom), 32'(8'h11 * (k + 1)), $urandom, 4'($urandom),
            4'($urandom), 4'($urandom), 1, 0);
      #1;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL stream_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
      end
      n_checks++;
      if (in_ready !== 1'b1 || occ > 2'd1) begin
        n_fail++;
        $display("FAIL stream_ready_occ k=%0d: got ready=%b occ=%0d expected ready=1 occ<=1",
                 k, in_ready, occ);
      end
      if (k > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || opa_o !== 32'(8'h11 * k)) begin
          n_fail++;
          $display("FAIL stream_order k=%0d: got valid=%b opa=%h expected valid=1 opa=%h",
                   k, out_valid, opa_o, 32'(8'h11 * k));
        end
      end
      tick();
    end
    drive(0, '0, '0, '0, '0, '0, '0, 1, 0);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || opa_o !== 32'h88) begin
      n_fail++;
      $display("FAIL stream_last: got valid=%b opa=%h expected valid=1 opa=00000088",
               out_valid, opa_o);
    end
    tick();
  endtask

  task automatic test_stall_skid();
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] vals[3];
    int                sent;
    logic              saw_low;
    vals[0] = 32'hA1; vals[1] = 32'hA2; vals[2] = 32'hA3;
    for (int k = 0; k < 3; k++) begin
      drive(1, 9'h004, vals[k], $urandom, 4'd1, 4'd2, 4'd3, 0, 0);
      #1;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL stall_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
      end
      tick();
    end
    #1;
    n_checks++;
    if (opa_o !== 32'hA1 || occ !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_full: got opa=%h occ=%0d ready=%b expected opa=a1 occ=2 ready=0",
               opa_o, occ, in_ready);
    end
    sent    = 2;
    saw_low = in_ready;
    for (int c = 0; c < 6; c++) begin
      drive(sent < 3, 9'h004, vals[2], '0, 4'd1, 4'd2, 4'd3, 1, 0);
      #1;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL release_model c=%0d: got %h expected %h", c, dut_vec, model_vec());
      end
      if (out_valid) got.push_back(opa_o);
      if (in_valid && in_ready) sent++;
      tick();
    end
    n_checks++;
    if (saw_low !== 1'b0 || got.size() != 3) begin
      n_fail++;
      $display("FAIL release_count: got ready_at_release=%b drained=%0d expected 0 and 3",
               saw_low, got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got[k] !== vals[k]) begin
          n_fail++;
          $display("FAIL release_order k=%0d: got %h expected %h", k, got[k], vals[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    drive(1, 9'h1FF, 32'hB1, '0, '0, '0, '0, 0, 0); tick();
    drive(1, 9'h1FF, 32'hB2, '0, '0, '0, '0, 0, 0); tick();
    drive(1, 9'h1FF, 32'hB3, '0, '0, '0, '0, 1, 1);
    #1;
    n_checks++;
    if (occ !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_pre: got occ=%0d expected 2", occ);
    end
    tick();
    drive(0, '0, '0, '0, '0, '0, '0, 1, 0);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || ctrl_o !== '0 || occ !== 2'd0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL flush_full: got %h expected %h", dut_vec, model_vec());
    end
    // Flush while the stage is open: concurrent accept must be discarded
    drive(1, 9'h1FF, 32'hC1, '0, '0, '0, '0, 0, 0); tick();
    drive(1, 9'h1FF, 32'hC2, '0, '0, '0, '0, 1, 1);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: got %b expected 1", in_ready);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, '0, '0, '0, '0, '0, 1, 0);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || opa_o === 32'hC2 || dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL flush_discard c=%0d: got %h expected %h", c, dut_vec, model_vec());
      end
      tick();
    end
  endtask

  task automatic test_bubble();
    drive(1, 9'h1FF, 32'h5A, 32'h77, 4'd1, 4'd2, 4'd3, 1, 0); tick();
    drive(0, '0, '0, '0, '0, '0, '0, 1, 0);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || ctrl_o !== 9'h1FF || opa_o !== 32'h5A) begin
      n_fail++;
      $display("FAIL bubble_load: got valid=%b ctrl=%h opa=%h expected 1 1ff 0000005a",
               out_valid, ctrl_o, opa_o);
    end
    tick();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || ctrl_o !== '0 || opa_o !== 32'h5A) begin
      n_fail++;
      $display("FAIL bubble_empty: got valid=%b ctrl=%h opa=%h expected 0 000 0000005a",
               out_valid, ctrl_o, opa_o);
    end
  endtask

  task automatic test_forwarding();
    drive(1, 9'h004, 32'h1, 32'h2, 4'd0, 4'd0, 4'd5, 0, 0); tick();
    drive(0, '0, '0, '0, 4'd5, 4'd6, '0, 0, 0);
    #1;
    n_checks++;
    if (fwd_a !== 1'b1 || fwd_b !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_wreg1: got a=%b b=%b expected a=1 b=0", fwd_a, fwd_b);
    end
    drive(0, '0, '0, '0, 4'd6, 4'd5, '0, 0, 0);
    #1;
    n_checks++;
    if (fwd_a !== 1'b0 || fwd_b !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_swap: got a=%b b=%b expected a=0 b=1", fwd_a, fwd_b);
    end
    drive(0, '0, '0, '0, '0, '0, '0, 1, 0); tick();
    drive(1, 9'h1FB, 32'h3, 32'h4, 4'd0, 4'd0, 4'd5, 0, 0); tick();
    drive(0, '0, '0, '0, 4'd5, 4'd5, '0, 0, 0);
    #1;
    n_checks++;
    if (fwd_a !== 1'b0 || fwd_b !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_wreg0: got a=%b b=%b valid=%b expected 0 0 1", fwd_a, fwd_b, out_valid);
    end
    drive(0, '0, '0, '0, '0, '0, '0, 1, 0); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, 9'($urandom), $urandom, $urandom,
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            ($urandom % 3) != 0, ($urandom % 16) == 0);
      #1;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random c=%0d: got %h expected %h", c, dut_vec, model_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1, 9'h1FF, 32'hE1, 32'h1, 4'd1, 4'd1, 4'd1, 0, 0); tick();
    drive(1, 9'h1FF, 32'hE2, 32'h2, 4'd1, 4'd1, 4'd1, 0, 0); tick();
    drive(1, 9'h1FF, 32'hE3, 32'h3, 4'd1, 4'd1, 4'd1, 0, 0);
    #1;
    n_checks++;
    if (occ !== 2'd2) begin
      n_fail++;
      $display("FAIL midrst_pre: got occ=%0d expected 2", occ);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec !== RESET_VEC) begin
      n_fail++;
      $display("FAIL midrst_async: got %h expected %h", dut_vec, RESET_VEC);
    end
    tick();
    rst = 1'b0;
    drive(1, 9'h010, 32'hF1, 32'h0, 4'd2, 4'd3, 4'd4, 1, 0);
    #1;
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL midrst_after: got %h expected %h", dut_vec, model_vec());
    end
    tick();
    drive(0, '0, '0, '0, '0, '0, '0, 1, 0);
    #1;
    n_checks++;
    if (dut_vec !== model_vec() || opa_o !== 32'hF1) begin
      n_fail++;
      $display("FAIL midrst_resume: got %h expected %h", dut_vec, model_vec());
    end
    tick();
  endtask

  initial begin
    last = '0;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_bubble();
    test_forwarding();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline boundary register for the CPU pipeline, the successor to the fixed-width stage latches. It carries a control word, two operand values and three register indices between stages. It adds a valid/ready handshake with a one-entry skid buffer, so `in_ready` is registered and throughput stays at one transfer per cycle. It also provides a synchronous flush that inserts bubbles, and registered-destination match flags for forwarding.

## Interface
- `DATA_W`, 32, width of each operand value
- `REG_W`, 4, width of each register index
- `CTRL_W`, 9, width of control word (packing {aluins[2:0], jmp[1:0], wpc, wreg, rmem, wmem}, bit 0 = wmem)
- `WREG_BIT`, 2, index in control word of the register-write enable
- `clk` in 1 — clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `flush` in 1 — synchronous kill of all held and incoming entries
- `in_valid` in 1 — upstream entry valid
- `in_ready` out 1 — stage can accept (registered)
- `ctrl_i` in CTRL_W; `opa_i`, `opb_i` in DATA_W; `ra_i`, `rb_i`, `dest_i` in REG_W — incoming payload
- `out_valid` out 1 — output entry valid
- `out_ready` in 1 — downstream accepts
- `ctrl_o` out CTRL_W; `opa_o`, `opb_o` out DATA_W; `ra_o`, `rb_o`, `dest_o` out REG_W — output payload (main slot)
- `occ` out 2 — entries held (0, 1, 2)
- `fwd_a`, `fwd_b` out 1 — held output entry writes `ra_i` / `rb_i`

## Operation
- Two slots: main (drives outputs) and skid. `in_ready` = !skid_valid, taken from a register.
- Accept = in_valid & in_ready & !flush. Drain = out_valid & out_ready.
- Main empty, or Drain with skid empty: Accept loads main.
- Main full, no Drain: Accept loads skid. `in_ready` falls the next cycle.
- Drain with skid full: main <- skid, skid empties. `in_ready` rises the next cycle. No Accept is possible that cycle, because `in_ready` was 0.
- Main empties with no refill: `ctrl_o` is cleared to 0 (bubble), so no memory, register or PC write is ever presented. Data and index outputs hold their last values.
- `flush` = 1: at the next edge both slots are invalid, `ctrl_o` is 0 and the skid control word is 0. An Accept in the same cycle is discarded, and the source sees `in_ready` as it was. Flush wins over Drain and Accept.
- `occ` = main_valid + skid_valid.
- `fwd_a` = out_valid & ctrl_o[WREG_BIT] & (dest_o == ra_i). `fwd_b` is the same using `rb_i`. Both are purely combinational from held state plus the index inputs. There is no register-0 exclusion.
- Reset (asynchronous, any time including mid-transfer): `out_valid` 0, `ctrl_o` 0, `opa_o`/`opb_o` 0, `ra_o`/`rb_o`/`dest_o` 0, `occ` 0, `in_ready` 1, skid cleared. `fwd_a`/`fwd_b` are 0 as a consequence.

## Timing
- Latency: 1 cycle from Accept edge to `out_valid` when main is empty.
- Throughput: 1 per cycle with `out_ready` held high. The skid is never used in that case.
- `in_ready` has no combinational path from `out_ready`, `in_valid` or `flush`.
- The skid absorbs exactly one entry after a downstream stall. `in_ready` is low for 1 cycle minimum after the stall clears.
- Ordering is strictly FIFO: skid content always leaves before any newer entry.
- Deassertion of `rst` is synchronous to `clk` by the integrator. The block adds no reset synchroniser.

## Test plan
- **Reset:** assert `rst` mid-stream with `occ` = 2 → same cycle all outputs 0, `in_ready` = 1, `occ` = 0.
- **Streaming:** 8 entries back-to-back, `out_ready` = 1, `opa_i` = 0x11..0x88 → `out_valid` from cycle 1, values in order, `occ` ≤ 1, `in_ready` always 1.
- **Stall and skid:** `out_ready` = 0 for 3 cycles while `in_valid` = 1 with 0xA1, 0xA2, 0xA3 → 0xA1 held on outputs, 0xA2 in skid, `in_ready` 0, `occ` = 2, 0xA3 held by source. On release, 0xA1, 0xA2, 0xA3 appear on consecutive drains with none lost or duplicated.
- **Flush with full slots plus concurrent Accept:** next cycle `out_valid` 0, `ctrl_o` = 0, `occ` 0. The accepted entry never appears.
- **Bubble:** single entry `ctrl_i` = 0x1FF drained, no refill → `ctrl_o` = 0, `out_valid` 0, `opa_o` unchanged.
- **Forwarding:** held `dest_o` = 5 with wreg = 1; `ra_i` = 5, `rb_i` = 6 → `fwd_a` 1, `fwd_b` 0. With wreg = 0 → both 0.
